// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal stream blocks: pixel layout,
// TLAST granularity encodings and the frame replayer FSM states.
package haze_pkg;
  localparam int PIXEL_W_DEF = 24;
  localparam int TDATA_W_DEF = 32;

  localparam int CH_W     = 8;
  localparam int CH_B_LSB = 0;
  localparam int CH_G_LSB = 8;
  localparam int CH_R_LSB = 16;

  localparam int TLAST_FRAME = 0;
  localparam int TLAST_ROW   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_GAP,
    ST_FIN
  } state_t;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction
endpackage

// File: rtl/frame_pixel_ram.sv
// One-image pixel store: independent write port and 1-cycle synchronous read port.
// No reset on the array or read register so it maps onto block RAM.
module frame_pixel_ram
  import haze_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PIXEL_W_DEF,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axis_frame_replayer.sv
// Replays a stored image NUM_PASSES times as AXI4-Stream; first beat 2 cycles after start.
// Full TREADY backpressure: reads are credit-limited into an output register plus one skid entry.
module axis_frame_replayer
  import haze_pkg::*;
#(
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int TDATA_W    = TDATA_W_DEF,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int NUM_PASSES = 2,
  parameter int GAP_CYCLES = 1,
  parameter int TLAST_MODE = TLAST_FRAME
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   wr_en,
  input  logic [max1($clog2(IMG_W*IMG_H))-1:0]   wr_addr,
  input  logic [PIXEL_W-1:0]                     wr_data,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic [max1($clog2(NUM_PASSES))-1:0]    pass_idx,
  output logic [TDATA_W-1:0]                     M_AXIS_TDATA,
  output logic                                   M_AXIS_TVALID,
  output logic                                   M_AXIS_TLAST,
  output logic                                   M_AXIS_TUSER,
  input  logic                                   M_AXIS_TREADY
);
  localparam int ADDR_W = max1($clog2(IMG_W*IMG_H));
  localparam int COL_W  = max1($clog2(IMG_W));
  localparam int ROW_W  = max1($clog2(IMG_H));
  localparam int PASS_W = max1($clog2(NUM_PASSES));
  localparam int GAP_W  = max1($clog2(GAP_CYCLES + 1));

  typedef struct packed {
    logic              last;
    logic              user;
    logic              eop;
    logic [PASS_W-1:0] pass;
  } sb_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] px;
    sb_t                sb;
  } beat_t;

  state_t             r_state, w_state_nxt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [PASS_W-1:0]  r_pass;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_iss_done, r_rd_vld;
  sb_t                r_rd_sb, w_iss_sb;
  logic [PIXEL_W-1:0] w_rd_px;
  beat_t              r_out, r_skid, w_rd_beat;
  logic               r_out_vld, r_skid_vld;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               w_start_acc, w_out_open, w_pop, w_issue, w_wr_en;
  logic               w_col_end, w_row_end, w_eop, w_final;
  logic [1:0]         w_occ;

  assign w_start_acc = start && (r_state == ST_IDLE || r_state == ST_FIN);
  assign w_wr_en     = wr_en && !busy;
  assign w_pop       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_col_end   = (r_col == COL_W'(IMG_W - 1));
  assign w_row_end   = (r_row == ROW_W'(IMG_H - 1));
  assign w_eop       = w_col_end && w_row_end;
  assign w_final     = w_eop && (r_pass == PASS_W'(NUM_PASSES - 1));

  // Buffered plus in-flight beats may never exceed the two buffer entries.
  assign w_occ   = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld} - {1'b0, w_pop};
  assign w_issue = busy && !r_iss_done && (w_occ < 2'd2);

  always_comb begin
    w_iss_sb      = '0;
    w_iss_sb.last = (TLAST_MODE == TLAST_ROW) ? w_col_end : w_eop;
    w_iss_sb.user = (r_col == '0) && (r_row == '0);
    w_iss_sb.eop  = w_eop;
    w_iss_sb.pass = r_pass;
  end

  frame_pixel_ram #(
    .DEPTH (IMG_W * IMG_H),
    .WIDTH (PIXEL_W),
    .AW    (ADDR_W)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_wr_en),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_re    (w_issue),
    .i_raddr (r_addr),
    .o_rdata (w_rd_px)
  );

  assign w_rd_beat = {w_rd_px, r_rd_sb};

  always_ff @(posedge ACLK) begin
    if (ARESET || w_start_acc) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pass     <= '0;
      r_addr     <= '0;
      r_iss_done <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_sb    <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_sb <= w_iss_sb;
        r_col   <= w_col_end ? '0 : r_col + COL_W'(1);
        if (w_col_end) r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
        r_addr  <= w_eop ? '0 : r_addr + ADDR_W'(1);
        if (w_eop && !w_final) r_pass <= r_pass + PASS_W'(1);
        if (w_final) r_iss_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || w_start_acc) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || w_pop) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid     <= w_rd_beat;
        r_skid_vld <= r_rd_vld;
      end else begin
        if (r_rd_vld) r_out <= w_rd_beat;
        r_out_vld <= r_rd_vld;
      end
    end else if (r_rd_vld) begin
      r_skid     <= w_rd_beat;
      r_skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || r_state != ST_GAP) r_gap_cnt <= '0;
    else                             r_gap_cnt <= r_gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_FIN: if (start) w_state_nxt = ST_PRIME;
      ST_PRIME:        w_state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (w_pop && r_out.sb.eop) begin
          if (r_out.sb.pass == PASS_W'(NUM_PASSES - 1)) w_state_nxt = ST_FIN;
          else if (GAP_CYCLES > 0)                      w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = ST_STREAM;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The next pass may already sit in the output register during GAP; it is only masked.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    w_out_open = 1'b0;
    case (r_state)
      ST_PRIME, ST_GAP: busy = 1'b1;
      ST_STREAM: begin
        busy       = 1'b1;
        w_out_open = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign M_AXIS_TVALID = r_out_vld && w_out_open;
  assign M_AXIS_TDATA  = TDATA_W'(r_out.px);
  assign M_AXIS_TLAST  = r_out.sb.last;
  assign M_AXIS_TUSER  = r_out.sb.user;
  assign pass_idx      = r_out.sb.pass;
endmodule

// File: tb/tb_axis_frame_replayer.sv
// Three 4x2 replayer configurations (frame TLAST/gap 1, row TLAST/gap 1, 3 passes/gap 0)
// share stimulus; every accepted beat is logged per instance and checked after each run.
module tb_axis_frame_replayer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, start, tready;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [31:0] tdata  [3];
  logic        tvalid [3];
  logic        tlast  [3];
  logic        tuser  [3];
  logic        busy   [3];
  logic        done   [3];
  logic [0:0]  pidx_a, pidx_b;
  logic [1:0]  pidx_c;
  logic [1:0]  pidx   [3];

  assign pidx[0] = {1'b0, pidx_a};
  assign pidx[1] = {1'b0, pidx_b};
  assign pidx[2] = pidx_c;

  axis_frame_replayer #(.PIXEL_W(24), .TDATA_W(32), .IMG_W(4), .IMG_H(2),
                        .NUM_PASSES(2), .GAP_CYCLES(1), .TLAST_MODE(0)) u_a (
    .ACLK(clk), .ARESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy[0]), .done(done[0]), .pass_idx(pidx_a),
    .M_AXIS_TDATA(tdata[0]), .M_AXIS_TVALID(tvalid[0]), .M_AXIS_TLAST(tlast[0]),
    .M_AXIS_TUSER(tuser[0]), .M_AXIS_TREADY(tready));

  axis_frame_replayer #(.PIXEL_W(24), .TDATA_W(32), .IMG_W(4), .IMG_H(2),
                        .NUM_PASSES(2), .GAP_CYCLES(1), .TLAST_MODE(1)) u_b (
    .ACLK(clk), .ARESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy[1]), .done(done[1]), .pass_idx(pidx_b),
    .M_AXIS_TDATA(tdata[1]), .M_AXIS_TVALID(tvalid[1]), .M_AXIS_TLAST(tlast[1]),
    .M_AXIS_TUSER(tuser[1]), .M_AXIS_TREADY(tready));

  axis_frame_replayer #(.PIXEL_W(24), .TDATA_W(32), .IMG_W(4), .IMG_H(2),
                        .NUM_PASSES(3), .GAP_CYCLES(0), .TLAST_MODE(0)) u_c (
    .ACLK(clk), .ARESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy[2]), .done(done[2]), .pass_idx(pidx_c),
    .M_AXIS_TDATA(tdata[2]), .M_AXIS_TVALID(tvalid[2]), .M_AXIS_TLAST(tlast[2]),
    .M_AXIS_TUSER(tuser[2]), .M_AXIS_TREADY(tready));

  int          cyc = 0;
  logic [31:0] bdat  [3][32];
  logic        blast [3][32];
  logic        buser [3][32];
  logic [1:0]  bpidx [3][32];
  int          bcyc  [3][32];
  int          nb [3], stab_err [3], dcyc [3], dcnt [3];
  logic        stl [3], hlast [3], huser [3], pdone [3];
  logic [31:0] hdat [3];

  bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  int checks = 0;
  int errors = 0;

  // Beat logger: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (stl[d] && (!tvalid[d] || tdata[d] !== hdat[d] ||
                     tlast[d] !== hlast[d] || tuser[d] !== huser[d]))
        stab_err[d]++;
      if (tvalid[d] && tready) begin
        if (nb[d] < 32) begin
          bdat[d][nb[d]]  = tdata[d];
          blast[d][nb[d]] = tlast[d];
          buser[d][nb[d]] = tuser[d];
          bpidx[d][nb[d]] = pidx[d];
          bcyc[d][nb[d]]  = cyc;
        end
        nb[d]++;
      end
      if (done[d] && !pdone[d]) begin
        dcyc[d] = cyc;
        dcnt[d]++;
      end
      stl[d]   = tvalid[d] && !tready;
      hdat[d]  = tdata[d];
      hlast[d] = tlast[d];
      huser[d] = tuser[d];
      pdone[d] = done[d];
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input int d, input int n, input int lm, input string nm);
    chk({nm, "_count"}, nb[d], n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_dat%0d", nm, i), bdat[d][i], 32'((i % 8) + 1));
      chk($sformatf("%s_user%0d", nm, i), 32'(buser[d][i]), 32'(i % 8 == 0));
      chk($sformatf("%s_last%0d", nm, i), 32'(blast[d][i]), 32'(i % lm == lm - 1));
      chk($sformatf("%s_pidx%0d", nm, i), 32'(bpidx[d][i]), 32'(i / 8));
    end
  endtask

  // Pulses start, then runs until all three instances report done (bounded).
  task automatic run(input bit bp, input bit inject, output int c0);
    int k;
    for (int d = 0; d < 3; d++) begin
      nb[d] = 0; dcnt[d] = 0; dcyc[d] = -1; stab_err[d] = 0;
      for (int i = 0; i < 32; i++) bdat[d][i] = 32'hDEADBEEF;
    end
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(done[0] && done[1] && done[2]) && k < 300) begin
      tready = bp ? pat[k % 8] : 1'b1;
      if (inject && k == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hFFFFFF;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    tready = 1'b1; start = 1'b0; wr_en = 1'b0;
    chk("run_timeout", 32'(k < 300), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int k;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; tready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      nb[d] = 0; stab_err[d] = 0; dcyc[d] = -1; dcnt[d] = 0;
      stl[d] = 1'b0; pdone[d] = 1'b0; hdat[d] = '0; hlast[d] = 1'b0; huser[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    for (int d = 0; d < 3; d += 2) begin
      chk($sformatf("rst%0d_tvalid", d), 32'(tvalid[d]), 32'd0);
      chk($sformatf("rst%0d_tlast", d), 32'(tlast[d]), 32'd0);
      chk($sformatf("rst%0d_tuser", d), 32'(tuser[d]), 32'd0);
      chk($sformatf("rst%0d_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst%0d_done", d), 32'(done[d]), 32'd0);
      chk($sformatf("rst%0d_pidx", d), 32'(pidx[d]), 32'd0);
      chk($sformatf("rst%0d_tdata", d), tdata[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 24'(i + 1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    // Plain replay with TREADY high on all three configurations.
    run(1'b0, 1'b0, c0);
    // start driven before edge c0+1 is sampled there; TVALID seen two edges later, at log cycle c0+3.
    chk("s1_first_valid", bcyc[0][0] - c0, 32'd3);
    check_seq(0, 16, 8, "s1");
    chk("s1_pass0_span", bcyc[0][7] - bcyc[0][0], 32'd7);
    chk("s1_gap", bcyc[0][8] - bcyc[0][7], 32'd2);
    chk("s1_pass1_span", bcyc[0][15] - bcyc[0][8], 32'd7);
    chk("s1_done_cycle", dcyc[0], bcyc[0][15] + 1);
    chk("s1_done_held", 32'(done[0]), 32'd1);
    chk("s1_busy_low", 32'(busy[0]), 32'd0);
    check_seq(1, 16, 4, "s2");
    check_seq(2, 24, 8, "s6");
    chk("s6_span", bcyc[2][23] - bcyc[2][0], 32'd23);
    chk("s6_pidx_at_done", 32'(pidx[2]), 32'd2);

    // Repeating TREADY pattern: same accepted sequence, held outputs while stalled.
    run(1'b1, 1'b0, c0);
    check_seq(0, 16, 8, "s3");
    chk("s3_stable", stab_err[0], 32'd0);
    check_seq(2, 24, 8, "s3c");
    chk("s3c_stable", stab_err[2], 32'd0);

    // start and a RAM write while busy are both ignored.
    run(1'b0, 1'b1, c0);
    check_seq(0, 16, 8, "s4");
    chk("s4_single_done", dcnt[0], 32'd1);
    run(1'b0, 1'b0, c0);
    chk("s4b_first_dat", bdat[0][0], 32'h000001);
    chk("s4b_count", nb[0], 32'd16);

    // Reset in the middle of pass 0 abandons the run.
    for (int d = 0; d < 3; d++) nb[d] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (nb[0] < 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s5_reach_beat5", 32'(k < 50), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_tvalid", 32'(tvalid[0]), 32'd0);
    chk("s5_busy", 32'(busy[0]), 32'd0);
    chk("s5_done", 32'(done[0]), 32'd0);
    @(posedge clk); #1;
    run(1'b0, 1'b0, c0);
    check_seq(0, 16, 8, "s5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
endmodule
